// File: rtl/hex_scan_driver.sv
// Purpose: time-multiplexed hex driver for a common-anode 7-segment bank.
//          Frames are double-buffered, each slot starts with a dark guard gap,
//          and the driver supports leading-zero blanking and per-digit blink.
// Ports:   Clk/Reset (async, active-high); En, Load, Value, DpIn, BlinkMask, LzbEn in;
//          Seg (active-low, dp in bit 7), Anode (active-low), FrameStart out.
//          All outputs are registered, one cycle after the scan state.
module hex_scan_driver #(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int GUARD     = 2,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  En,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   Value,
    input  logic [DIGITS-1:0]     DpIn,
    input  logic [DIGITS-1:0]     BlinkMask,
    input  logic                  LzbEn,
    output logic [7:0]            Seg,
    output logic [DIGITS-1:0]     Anode,
    output logic                  FrameStart
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [CW-1:0] CNT_MAX  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);
    localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS - 1);
    localparam logic [BW-1:0] BCNT_MAX = BW'(BLINK_DIV - 1);

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [BW-1:0]         bcnt;
    logic                  phase;

    logic [4*DIGITS-1:0]   pend_val;
    logic [DIGITS-1:0]     pend_dp;
    logic [DIGITS-1:0]     pend_blink;
    logic                  pend_v;

    logic [4*DIGITS-1:0]   sh_val;
    logic [DIGITS-1:0]     sh_dp;
    logic [DIGITS-1:0]     sh_blink;

    // Delays the boundary by one cycle so FrameStart lines up with the
    // registered digit-0 guard slot; it is 0 after reset, so no pulse is
    // produced until the first real frame wrap.
    logic                  fs_arm;

    logic                  cnt_wrap;
    logic                  boundary;

    logic [3:0]            nib;
    logic                  dp_sel;
    logic                  blink_sel;
    logic                  lz_sel;
    logic [DIGITS-1:0]     lz_zero;
    logic                  all_zero;
    logic                  blink_blank;
    logic [6:0]            glyph;
    logic                  dp_on;
    logic [DIGITS-1:0]     anode_nxt;
    logic [7:0]            seg_nxt;

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: hex_glyph = 7'h40;
            4'h1: hex_glyph = 7'h79;
            4'h2: hex_glyph = 7'h24;
            4'h3: hex_glyph = 7'h30;
            4'h4: hex_glyph = 7'h19;
            4'h5: hex_glyph = 7'h12;
            4'h6: hex_glyph = 7'h02;
            4'h7: hex_glyph = 7'h78;
            4'h8: hex_glyph = 7'h00;
            4'h9: hex_glyph = 7'h10;
            4'hA: hex_glyph = 7'h08;
            4'hB: hex_glyph = 7'h03;
            4'hC: hex_glyph = 7'h46;
            4'hD: hex_glyph = 7'h21;
            4'hE: hex_glyph = 7'h06;
            default: hex_glyph = 7'h0E;
        endcase
    endfunction

    assign cnt_wrap = (cnt == CNT_MAX);
    assign boundary = cnt_wrap && (idx == IDX_MAX);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt        <= '0;
            idx        <= '0;
            bcnt       <= '0;
            phase      <= 1'b0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_blink <= '0;
            pend_v     <= 1'b0;
            sh_val     <= '0;
            sh_dp      <= '0;
            sh_blink   <= '0;
            fs_arm     <= 1'b0;
            FrameStart <= 1'b0;
            Anode      <= '1;
            Seg        <= 8'hFF;
        end else begin
            cnt <= cnt_wrap ? '0 : cnt + 1'b1;
            if (cnt_wrap) begin
                idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            end

            if (bcnt == BCNT_MAX) begin
                bcnt  <= '0;
                phase <= ~phase;
            end else begin
                bcnt  <= bcnt + 1'b1;
            end

            // A load landing exactly on the frame boundary goes straight to
            // the shadow so it is not delayed by a whole extra frame.
            if (boundary && Load) begin
                sh_val   <= Value;
                sh_dp    <= DpIn;
                sh_blink <= BlinkMask;
                pend_v   <= 1'b0;
            end else if (boundary && pend_v) begin
                sh_val   <= pend_val;
                sh_dp    <= pend_dp;
                sh_blink <= pend_blink;
                pend_v   <= 1'b0;
            end else if (Load) begin
                pend_val   <= Value;
                pend_dp    <= DpIn;
                pend_blink <= BlinkMask;
                pend_v     <= 1'b1;
            end

            fs_arm     <= boundary;
            FrameStart <= fs_arm;
            Anode      <= anode_nxt;
            Seg        <= seg_nxt;
        end
    end

    always_comb begin
        nib       = '0;
        dp_sel    = 1'b0;
        blink_sel = 1'b0;
        lz_sel    = 1'b0;
        lz_zero   = '0;
        all_zero  = 1'b1;

        // lz_zero[i] is set when nibbles i..DIGITS-1 are all zero.
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero   = all_zero && (sh_val[4*i +: 4] == 4'h0);
            lz_zero[i] = all_zero;
        end

        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib       = sh_val[4*i +: 4];
                dp_sel    = sh_dp[i];
                blink_sel = sh_blink[i];
                lz_sel    = (i != 0) && lz_zero[i];
            end
        end

        blink_blank = blink_sel && phase;
        // Leading-zero blanking keeps the decimal point; blink blanking does not.
        dp_on       = dp_sel && !blink_blank;
        glyph       = (blink_blank || (LzbEn && lz_sel)) ? 7'h7F : hex_glyph(nib);

        if ((cnt < GUARD_C) || !En) begin
            anode_nxt = '1;
            seg_nxt   = 8'hFF;
        end else begin
            anode_nxt = ~(DIGITS'(1) << idx);
            seg_nxt   = {~dp_on, glyph};
        end
    end

endmodule

// File: tb/tb_hex_scan_driver.sv
// Bench for hex_scan_driver with DIGITS=4, SCAN_DIV=4, GUARD=1, BLINK_DIV=32.
// Expected per-cycle {FrameStart, Anode, Seg} triples are queued when stimulus
// is driven and popped as the DUT produces each registered output cycle.
module tb_hex_scan_driver;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        En = 1'b1;
    logic        Load = 1'b0;
    logic [15:0] Value = '0;
    logic [3:0]  DpIn = '0;
    logic [3:0]  BlinkMask = '0;
    logic        LzbEn = 1'b0;
    logic [7:0]  Seg;
    logic [3:0]  Anode;
    logic        FrameStart;

    int n_tests = 0;
    int n_fail  = 0;
    logic [12:0] sb[$];

    hex_scan_driver #(
        .DIGITS(4), .SCAN_DIV(4), .GUARD(1), .BLINK_DIV(32)
    ) dut (
        .Clk(Clk), .Reset(Reset), .En(En), .Load(Load), .Value(Value),
        .DpIn(DpIn), .BlinkMask(BlinkMask), .LzbEn(LzbEn),
        .Seg(Seg), .Anode(Anode), .FrameStart(FrameStart)
    );

    always #5 Clk = ~Clk;

    // Frame cycle k: k%4==0 is the guard gap of digit k/4, otherwise digit k/4 is lit.
    function automatic logic [12:0] exp_entry(input int k, input logic [7:0] s0,
                                              input logic [7:0] s1, input logic [7:0] s2,
                                              input logic [7:0] s3);
        int d;
        logic [7:0] s;
        logic [3:0] one;
        d   = k / 4;
        one = 4'b0001;
        case (d)
            0: s = s0;
            1: s = s1;
            2: s = s2;
            default: s = s3;
        endcase
        if (k % 4 == 0) return {(k == 0), 4'hF, 8'hFF};
        return {1'b0, ~(one << d), s};
    endfunction

    task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3);
        for (int k = 0; k < 16; k++) sb.push_back(exp_entry(k, s0, s1, s2, s3));
    endtask

    task automatic check_cycle(input string tag);
        logic [12:0] exp_v;
        logic [12:0] obs;
        n_tests++;
        exp_v = 13'h0;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL %s: scoreboard empty, got fs=%b an=%h seg=%h", tag, FrameStart, Anode, Seg);
        end
        if (sb.size() > 0) begin
            exp_v = sb.pop_front();
            obs   = {FrameStart, Anode, Seg};
            assert (obs === exp_v) else begin
                n_fail++;
                $error("FAIL %s: got fs=%b an=%h seg=%h, expected fs=%b an=%h seg=%h",
                       tag, obs[12], obs[11:8], obs[7:0], exp_v[12], exp_v[11:8], exp_v[7:0]);
            end
        end
        @(posedge Clk); #1;
    endtask

    // Checks one queued frame; optionally pulses Load at frame cycles la and lb.
    task automatic run_frame(input string tag, input int la, input logic [15:0] va,
                             input int lb, input logic [15:0] vb);
        for (int k = 0; k < 16; k++) begin
            Load  = (k == la) || (k == lb);
            Value = (k == lb) ? vb : va;
            check_cycle(tag);
        end
        Load = 1'b0;
    endtask

    // Counts cycles from reset release until the first FrameStart (bounded).
    task automatic first_fs(input string tag);
        int n;
        n = 0;
        do begin
            @(posedge Clk); #1;
            Load = 1'b0;
            n++;
        end while (!FrameStart && n < 40);
        n_tests++;
        assert (n == 17) else begin
            n_fail++;
            $error("FAIL %s: first FrameStart after %0d cycles, expected 17", tag, n);
        end
    endtask

    initial begin
        logic [12:0] e;

        // Reset state
        @(posedge Clk); #1;
        n_tests++;
        assert ({FrameStart, Anode, Seg} === 13'h0_F_FF) else begin
            n_fail++;
            $error("FAIL reset_state: got fs=%b an=%h seg=%h, expected fs=0 an=f seg=ff",
                   FrameStart, Anode, Seg);
        end

        // 1: release reset, load 12AF in the first cycle
        Reset = 1'b0;
        Load  = 1'b1;
        Value = 16'h12AF;
        first_fs("t1_first_fs");

        // Frame 1 shows 12AF; 0000 then 3333 are loaded mid-frame (2: tear-free)
        push_frame(8'h8E, 8'h88, 8'hA4, 8'hF9);
        run_frame("t1_12af", 1, 16'h0000, 8, 16'h3333);

        // Frame 2 shows 3333; 5555 pending, then 8888 on the boundary cycle (3)
        push_frame(8'hB0, 8'hB0, 8'hB0, 8'hB0);
        run_frame("t2_3333", 2, 16'h5555, 14, 16'h8888);

        push_frame(8'h80, 8'h80, 8'h80, 8'h80);
        run_frame("t3_bypass", -1, 16'h0, -1, 16'h0);

        // Frame 4 must still be 8888 (stale 5555 must not commit); load 0050
        LzbEn = 1'b1;
        DpIn  = 4'b1000;
        push_frame(8'h80, 8'h80, 8'h80, 8'h80);
        run_frame("t3_hold", 0, 16'h0050, -1, 16'h0);

        // 4: leading-zero blanking
        push_frame(8'hC0, 8'h92, 8'hFF, 8'h7F);
        run_frame("t4_lzb", -1, 16'h0, -1, 16'h0);

        LzbEn     = 1'b0;
        DpIn      = 4'b0000;
        BlinkMask = 4'b0001;
        push_frame(8'hC0, 8'h92, 8'hC0, 8'h40);
        run_frame("t4_nolzb", 0, 16'h0001, -1, 16'h0);

        // 5: blink phase flips every 32 cycles = every two frames (frames 7..10)
        push_frame(8'hFF, 8'hC0, 8'hC0, 8'hC0);
        run_frame("t5_blink_f7", -1, 16'h0, -1, 16'h0);
        push_frame(8'hF9, 8'hC0, 8'hC0, 8'hC0);
        run_frame("t5_blink_f8", -1, 16'h0, -1, 16'h0);
        push_frame(8'hF9, 8'hC0, 8'hC0, 8'hC0);
        run_frame("t5_blink_f9", -1, 16'h0, -1, 16'h0);
        push_frame(8'hFF, 8'hC0, 8'hC0, 8'hC0);
        run_frame("t5_blink_f10", -1, 16'h0, -1, 16'h0);

        // 6a: En dropped for one cycle while digit 1 is lit (frame 11)
        for (int k = 0; k < 16; k++) begin
            e = exp_entry(k, 8'hFF, 8'hC0, 8'hC0, 8'hC0);
            if (k == 6) e = {1'b0, 4'hF, 8'hFF};
            sb.push_back(e);
        end
        for (int k = 0; k < 16; k++) begin
            if (k == 5) En = 1'b0;
            if (k == 6) En = 1'b1;
            check_cycle("t6_en");
        end

        // 6b: frame 12 starts on time; load 7777 into pending, then reset mid-slot
        for (int k = 0; k < 3; k++) sb.push_back(exp_entry(k, 8'hF9, 8'hC0, 8'hC0, 8'hC0));
        check_cycle("t6_pre_reset");
        Load  = 1'b1;
        Value = 16'h7777;
        check_cycle("t6_pre_reset");
        Load  = 1'b0;
        check_cycle("t6_pre_reset");
        #2;
        Reset = 1'b1;
        #1;
        n_tests++;
        assert ({FrameStart, Anode, Seg} === 13'h0_F_FF) else begin
            n_fail++;
            $error("FAIL t6_async_reset: got fs=%b an=%h seg=%h, expected fs=0 an=f seg=ff",
                   FrameStart, Anode, Seg);
        end
        @(posedge Clk); #1;
        Reset = 1'b0;
        first_fs("t6_first_fs");
        // Shadow cleared and pending 7777 lost
        push_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0);
        run_frame("t6_after_reset", -1, 16'h0, -1, 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hex_scan_driver.md
# hex_scan_driver

Time-multiplexed, parametrised hexadecimal display driver for common-anode 7-segment banks. Accepts a packed multi-nibble value with per-digit decimal points, double-buffers it so the display never tears mid-frame, and scans one digit at a time with an anti-ghosting guard gap. It also provides leading-zero blanking and per-digit blinking. It sits between game/debug logic and the board's shared segment bus, replacing per-digit static decoders.

## Interface
- `DIGITS`, default 4: number of digits scanned, from 1 to 8.
- `SCAN_DIV`, default 50000: clock cycles each digit stays selected. Must be ≥ 2.
- `GUARD`, default 2: cycles at the start of each digit slot with all anodes off. Must be < `SCAN_DIV`.
- `BLINK_DIV`, default 25000000: cycles per blink half-period.
- `Clk` in, 1: system clock.
- `Reset` in, 1: asynchronous, active-high.
- `En` in, 1: display enable. When 0, all outputs are dark and the counters keep running.
- `Load` in, 1: single-cycle strobe that captures `Value`, `DpIn` and `BlinkMask` into the pending buffer.
- `Value` in, 4·`DIGITS`: nibble *i* is shown on digit *i*; digit 0 is least significant.
- `DpIn` in, `DIGITS`: decimal point per digit, 1 = lit.
- `BlinkMask` in, `DIGITS`: 1 = the digit blinks.
- `LzbEn` in, 1: leading-zero blanking enable. Sampled live, not buffered.
- `Seg` out, 8: active-low segments. Bit 7 is dp, bits 6..0 are g..a.
- `Anode` out, `DIGITS`: active-low digit select, one-hot or all-ones.
- `FrameStart` out, 1: one-cycle pulse when digit 0 begins a new slot.

## Operation
- **Registers**
  - `cnt`: scan counter, range 0..`SCAN_DIV`-1.
  - `idx`: digit index, range 0..`DIGITS`-1.
  - `bcnt`: blink counter, range 0..`BLINK_DIV`-1.
  - `phase`: blink phase, 1 bit.
  - Pending buffer plus `pend_v` valid flag.
  - Shadow buffer: the only source for the display.
- **Scan:** `cnt` increments every cycle. At `SCAN_DIV`-1 it wraps to 0 and `idx` advances, with `DIGITS`-1 wrapping to 0.
- **Wrap point:** the cycle where `cnt`=`SCAN_DIV`-1 and `idx`=`DIGITS`-1 is the frame boundary.
- **Commit:** at the frame boundary, if `pend_v`=1, pending is copied to shadow and `pend_v` clears.
- **Load:** each `Load` overwrites pending and sets `pend_v`, so the last load before a boundary wins.
- **Load on the boundary cycle:** the incoming data bypasses pending, commits to shadow directly, and `pend_v` ends at 0.
- **Blink:** `bcnt` is free-running. At `BLINK_DIV`-1 it wraps and `phase` toggles.
- **Glyph table** (hex, bits g..a): 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E.
- **Digit *i* blanking:** the glyph is forced to 7F when either condition holds:
  - `LzbEn`=1, i≠0, and shadow nibbles *i*..`DIGITS`-1 are all zero.
  - `BlinkMask`[i]=1 (shadow copy) and `phase`=1.
- **dp during blanking:**
  - dp still follows `DpIn`[i] when the digit is leading-zero blanked.
  - dp goes dark when the digit is blink-blanked.
- **Anode/Seg:**
  - While `cnt` < `GUARD`, or `En`=0, `Anode` is all ones and `Seg`=FF.
  - Otherwise `Anode`=~(1<<`idx`) and `Seg`={~dp, glyph}.

## Timing
- **Reset values:**
  - Counters, `idx`, `phase`, shadow, pending and `pend_v` all reset to 0.
  - `Anode` resets to all ones, `Seg` to FF, `FrameStart` to 0.
- **Reset mid-scan:** outputs go dark immediately (asynchronous), and scanning restarts from digit 0 with `cnt`=0. Pending data is lost.
- **Output registration:**
  - `Anode`, `Seg` and `FrameStart` are registered, one cycle after the `cnt`/`idx`/shadow state that produced them.
  - `FrameStart` is 1 in the cycle after `cnt` goes 0 with `idx`=0.
  - The first `FrameStart` after reset release occurs one full frame later, at cycle `DIGITS`·`SCAN_DIV`+1. No pulse is produced coming out of reset.
- **Display latency:** a `Load` appears on digit 0 at the first frame boundary at or after the `Load`, plus 1 cycle. The worst case is `DIGITS`·`SCAN_DIV`+1 cycles.
- **`En` and `LzbEn`:** changes take effect on the next registered output, with no frame alignment.
- **`DIGITS`=1:** every `cnt` wrap is a frame boundary, and leading-zero blanking never blanks.

## Test plan
Parameters for all scenarios: `DIGITS`=4, `SCAN_DIV`=4, `GUARD`=1, `BLINK_DIV`=32.

1. **Reset scan:** release `Reset`, then load `Value`=16'h12AF with `DpIn`=0 → per 4-cycle slot:
   - 1 dark cycle (`Anode`=F, `Seg`=FF).
   - 3 cycles showing, on their boundary commit: digit0 `Anode`=E with `Seg`=8E, digit1 `Anode`=D with `Seg`=88, digit2 `Anode`=B with `Seg`=A4, digit3 `Anode`=7 with `Seg`=F9.
   - `FrameStart` pulses every 16 cycles.
2. **Tear-free update:** `Load` 16'h0000, then `Load` 16'h3333 mid-frame → digits keep their old glyphs until the boundary. From the next frame every digit shows `Seg`=B0; 0000 is never displayed.
3. **Boundary bypass:** assert `Load` exactly on the wrap cycle with 16'h8888 → the next frame shows `Seg`=80 on all digits, and `pend_v`=0 afterwards.
4. **Leading-zero blanking:** `Value`=16'h0050, `DpIn`=4'b1000, `LzbEn`=1 → results per digit:
   - digit3 `Seg`=7F: blanked but dp lit.
   - digit2 `Seg`=FF.
   - digit1 `Seg`=92.
   - digit0 `Seg`=C0.
   - Dropping `LzbEn` makes digit2 show C0.
5. **Blink:** `BlinkMask`=4'b0001 with value 1 → digit0 alternates between F9 and FF every 32 cycles, while the other digits are unaffected.
6. **En/reset mid-operation:**
   - `En`=0 → `Anode`=F and `Seg`=FF on the next cycle while `cnt` keeps counting.
   - Asserting `Reset` mid-slot → outputs dark in the same cycle, and the shadow clears to 0.
